// File: rtl/mercury_ifu.sv
// Instruction fetch unit: credit-limited fetch requests, in-order response pairing and an instruction queue toward decode.
// Optional performance counters are built when MERCURY_IFU_PERF_EN is defined.
module mercury_ifu #(
   parameter logic [31:0] RESET_PC    = 32'h0000_0000,
   parameter int          QUEUE_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   output logic        req_valid,
   input  logic        req_ready,
   output logic [31:0] req_addr,
   input  logic        rsp_valid,
   input  logic [31:0] rsp_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst_data,
   output logic [31:0] inst_pc
`ifdef MERCURY_IFU_PERF_EN
   ,
   output logic [31:0] perf_fetch_cnt,
   output logic [31:0] perf_stall_cnt
`endif
);

   localparam int AW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
   localparam int CW = AW + 1;
   localparam logic [CW:0] QD_L = (CW+1)'(QUEUE_DEPTH);

   logic [31:0]   fetch_pc;
   logic [CW-1:0] oc;
   logic [CW-1:0] dc;
   logic [CW-1:0] qc;

   logic [31:0]   pcq [QUEUE_DEPTH];
   logic [AW-1:0] pcq_wr;
   logic [AW-1:0] pcq_rd;

   logic [31:0]   iq_pc   [QUEUE_DEPTH];
   logic [31:0]   iq_data [QUEUE_DEPTH];
   logic [AW-1:0] iq_wr;
   logic [AW-1:0] iq_rd;

   logic          req_fire;
   logic          rsp_take;
   logic          rsp_enq;
   logic          inst_pop;
   logic [CW:0]   inflight;
   logic [CW-1:0] oc_nx;
   logic [CW-1:0] qc_nx;

   // Queue entries plus outstanding requests never exceed the queue depth, so
   // every response already has a reserved queue slot.
   assign inflight  = {1'b0, qc} + {1'b0, oc};
   assign req_valid = !rst && !redirect_valid && (inflight < QD_L);
   assign req_addr  = fetch_pc & ~32'h3;
   assign req_fire  = req_valid && req_ready;

   // A response with nothing outstanding is a protocol error and is ignored.
   assign rsp_take  = rsp_valid && (oc != '0);
   assign rsp_enq   = rsp_take && (dc == '0) && !redirect_valid;

   assign inst_valid = !rst && (qc != '0);
   assign inst_data  = inst_valid ? iq_data[iq_rd] : 32'h0;
   assign inst_pc    = inst_valid ? iq_pc[iq_rd]   : 32'h0;
   assign inst_pop   = inst_valid && inst_ready && !redirect_valid;

   assign oc_nx = oc + CW'(req_fire) - CW'(rsp_take);
   assign qc_nx = qc + CW'(rsp_enq) - CW'(inst_pop);

   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc <= RESET_PC;
         oc       <= '0;
         dc       <= '0;
         qc       <= '0;
         pcq_wr   <= '0;
         pcq_rd   <= '0;
         iq_wr    <= '0;
         iq_rd    <= '0;
      end else begin
         oc <= oc_nx;
         if (req_fire) pcq_wr <= pcq_wr + 1'b1;
         if (rsp_take) pcq_rd <= pcq_rd + 1'b1;
         if (redirect_valid) begin
            // Everything still in flight belongs to the old path and is dropped on arrival.
            fetch_pc <= redirect_pc & ~32'h3;
            dc       <= oc_nx;
            qc       <= '0;
            iq_wr    <= '0;
            iq_rd    <= '0;
         end else begin
            if (req_fire) fetch_pc <= fetch_pc + 32'd4;
            if (rsp_take && (dc != '0)) dc <= dc - 1'b1;
            qc <= qc_nx;
            if (rsp_enq)  iq_wr <= iq_wr + 1'b1;
            if (inst_pop) iq_rd <= iq_rd + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (req_fire) pcq[pcq_wr] <= req_addr;
      if (rsp_enq) begin
         iq_pc[iq_wr]   <= pcq[pcq_rd];
         iq_data[iq_wr] <= rsp_data;
      end
   end

`ifdef MERCURY_IFU_PERF_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_fetch_cnt <= 32'h0;
         perf_stall_cnt <= 32'h0;
      end else begin
         if (req_fire)    perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
         if (!inst_valid) perf_stall_cnt <= perf_stall_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_mercury_ifu.sv
// Bench for mercury_ifu: variable-latency memory model, scoreboard of fetched {pc, data} pairs, directed scenarios.
module tb_mercury_ifu;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_addr;
   logic        rsp_valid;
   logic [31:0] rsp_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst_data;
   logic [31:0] inst_pc;
`ifdef MERCURY_IFU_PERF_EN
   logic [31:0] perf_fetch_cnt;
   logic [31:0] perf_stall_cnt;
   logic [31:0] fetch_exp;
   logic [31:0] stall_exp;
`endif

   int total = 0;
   int bad   = 0;

   logic [63:0] sb[$];
   logic [3:0]  pv;
   logic [31:0] pa [4];
   logic [1:0]  latm1;
   logic        inj;

   always #5 clk = ~clk;

   mercury_ifu #(.RESET_PC(32'h8000_0000), .QUEUE_DEPTH(4)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .inst_valid(inst_valid), .inst_ready(inst_ready),
      .inst_data(inst_data), .inst_pc(inst_pc)
`ifdef MERCURY_IFU_PERF_EN
      , .perf_fetch_cnt(perf_fetch_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
   );

   function automatic logic [31:0] memf(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'hC3C3_5A5A;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Memory: fixed latency latm1+1 cycles, in order, never stalls.
   always @(posedge clk) begin
      if (rst) begin
         pv <= 4'h0;
      end else begin
         pv    <= {pv[2:0], req_valid && req_ready};
         pa[0] <= req_addr;
         pa[1] <= pa[0];
         pa[2] <= pa[1];
         pa[3] <= pa[2];
      end
   end
   assign rsp_valid = pv[latm1] || inj;
   assign rsp_data  = memf(pa[latm1]);

`ifdef MERCURY_IFU_PERF_EN
   always @(posedge clk) begin
      if (rst) fetch_exp <= 32'h0;
      else if (req_valid && req_ready) fetch_exp <= fetch_exp + 32'd1;
   end
`endif

   // Scoreboard: accepted requests are expected back in order; a redirect or reset voids them all.
   always @(negedge clk) begin
`ifdef MERCURY_IFU_PERF_EN
      if (rst) stall_exp = 32'h0;
      else if (!inst_valid) stall_exp = stall_exp + 32'd1;
`endif
      if (rst || redirect_valid) begin
         sb.delete();
      end else begin
         if (inst_valid && inst_ready) begin
            if (sb.size() == 0) begin
               chk("unexpected_pop", {inst_pc, inst_data}, 64'h0);
            end else begin
               chk("inst_pc_data", {inst_pc, inst_data}, sb.pop_front());
            end
         end
         if (req_valid && req_ready) sb.push_back({req_addr, memf(req_addr)});
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_inst(input string nm);
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (inst_valid) return;
      end
      chk(nm, {63'h0, inst_valid}, 64'h1);
   endtask

   task automatic next_hs(input string nm, output logic [31:0] a);
      a = 32'hDEAD_BEEF;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (req_valid && req_ready) begin
            a = req_addr;
            return;
         end
      end
      chk(nm, {63'h0, req_valid}, 64'h1);
   endtask

   task automatic do_reset(input logic [1:0] lat);
      tick();
      rst = 1'b1;
      latm1 = lat;
      repeat (2) tick();
      rst = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, expected finish well before");
      $fatal(1);
   end

   initial begin
      logic [31:0] a;
      int pops;
      rst = 1'b1; req_ready = 1'b1; inst_ready = 1'b0;
      redirect_valid = 1'b0; redirect_pc = 32'h0; inj = 1'b0; latm1 = 2'd0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_req_valid",  {63'h0, req_valid},  64'h0);
      chk("rst_inst_valid", {63'h0, inst_valid}, 64'h0);
      chk("rst_inst_data",  {32'h0, inst_data},  64'h0);
      chk("rst_inst_pc",    {32'h0, inst_pc},    64'h0);
      tick();
      rst = 1'b0;

      // Boot sequence: four fetches from RESET_PC, then the credit runs out.
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (i < 4) begin
            chk("boot_req_valid", {63'h0, req_valid}, 64'h1);
            chk("boot_addr", {32'h0, req_addr}, {32'h0, 32'h8000_0000 + 32'(4 * i)});
         end else begin
            chk("boot_credit", {63'h0, req_valid}, 64'h0);
         end
      end

      // Backpressure: queue stays full and head stays first instruction.
      repeat (10) @(negedge clk);
      chk("full_req_valid",  {63'h0, req_valid},  64'h0);
      chk("full_inst_valid", {63'h0, inst_valid}, 64'h1);
      chk("full_head_pc",    {32'h0, inst_pc},    {32'h0, 32'h8000_0000});
      chk("full_head_data",  {32'h0, inst_data},  {32'h0, memf(32'h8000_0000)});

      // Streaming with 1-cycle memory: one instruction per cycle.
      tick();
      inst_ready = 1'b1;
      repeat (8) @(negedge clk);
      pops = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (inst_valid && inst_ready) pops++;
      end
      chk("stream_rate", 64'(pops), 64'd10);
      tick();
      req_ready = 1'b0;
      repeat (6) @(negedge clk);
      chk("drain_empty", 64'(sb.size()), 64'd0);
      chk("drain_inst_valid", {63'h0, inst_valid}, 64'h0);

      // Redirect with exactly two requests outstanding on a 3-cycle memory.
      do_reset(2'd2);
      tick();
      req_ready = 1'b1;
      tick();
      tick();
      req_ready = 1'b0;
      redirect_valid = 1'b1;
      redirect_pc = 32'h0000_1002;
      @(negedge clk);
      chk("redir_req_valid", {63'h0, req_valid}, 64'h0);
      tick();
      redirect_valid = 1'b0;
      req_ready = 1'b1;
      @(negedge clk);
      chk("redir_flush", {63'h0, inst_valid}, 64'h0);
      chk("redir_addr", {32'h0, req_addr}, {32'h0, 32'h0000_1000});
      wait_inst("redir_timeout");
      chk("redir_first_pc", {32'h0, inst_pc}, {32'h0, 32'h0000_1000});

      // Redirect in the same cycle as a response and an accepted head.
      repeat (10) tick();
      for (int i = 0; i < 40; i++) begin
         if (rsp_valid && inst_valid) break;
         tick();
      end
      chk("coinc_setup", {62'h0, rsp_valid, inst_valid}, 64'h3);
      redirect_valid = 1'b1;
      redirect_pc = 32'h0000_2000;
      tick();
      redirect_valid = 1'b0;
      @(negedge clk);
      chk("coinc_flush", {63'h0, inst_valid}, 64'h0);
      wait_inst("coinc_timeout");
      chk("coinc_first_pc", {32'h0, inst_pc}, {32'h0, 32'h0000_2000});

      // Back-to-back redirects: the last one wins.
      tick();
      redirect_valid = 1'b1;
      redirect_pc = 32'h0000_3000;
      tick();
      redirect_pc = 32'h0000_4000;
      tick();
      redirect_valid = 1'b0;
      next_hs("b2b_timeout", a);
      chk("b2b_addr", {32'h0, a}, {32'h0, 32'h0000_4000});
      wait_inst("b2b_inst_timeout");
      chk("b2b_first_pc", {32'h0, inst_pc}, {32'h0, 32'h0000_4000});

      // Address wrap at the top of the address space.
      tick();
      redirect_valid = 1'b1;
      redirect_pc = 32'hFFFF_FFFE;
      tick();
      redirect_valid = 1'b0;
      next_hs("wrap_timeout0", a);
      chk("wrap_addr0", {32'h0, a}, {32'h0, 32'hFFFF_FFFC});
      next_hs("wrap_timeout1", a);
      chk("wrap_addr1", {32'h0, a}, {32'h0, 32'h0000_0000});
      wait_inst("wrap_inst_timeout");
      chk("wrap_first_pc", {32'h0, inst_pc}, {32'h0, 32'hFFFF_FFFC});

      // Stray response with nothing outstanding must change nothing.
      tick();
      req_ready = 1'b0;
      repeat (10) tick();
      inj = 1'b1;
      tick();
      inj = 1'b0;
      @(negedge clk);
      chk("stray_no_enq", {63'h0, inst_valid}, 64'h0);
      chk("stray_credit", {63'h0, req_valid}, 64'h1);

      // Fill the queue, check counters, then reset in the middle of it.
      tick();
      req_ready = 1'b1;
      inst_ready = 1'b0;
      repeat (12) tick();
`ifdef MERCURY_IFU_PERF_EN
      chk("perf_fetch", {32'h0, perf_fetch_cnt}, {32'h0, fetch_exp});
      chk("perf_stall", {32'h0, perf_stall_cnt}, {32'h0, stall_exp});
`endif
      chk("midrst_pre_full", {63'h0, inst_valid}, 64'h1);
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_inst_valid", {63'h0, inst_valid}, 64'h0);
      chk("midrst_inst_data",  {32'h0, inst_data},  64'h0);
      chk("midrst_inst_pc",    {32'h0, inst_pc},    64'h0);
      chk("midrst_req_valid",  {63'h0, req_valid},  64'h0);
      latm1 = 2'd0;
      tick();
      tick();
      rst = 1'b0;
      inst_ready = 1'b1;
      @(negedge clk);
      chk("post_rst_addr", {32'h0, req_addr}, {32'h0, 32'h8000_0000});
      repeat (8) @(negedge clk);
      chk("post_rst_stream", {63'h0, inst_valid}, 64'h1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
